// File: rtl/bfm_ahbl_slave.sv
// AHB-Lite slave model: word-organised internal memory, configurable wait
// states on OKAY transfers and a two-cycle ERROR response for illegal ones.
module bfm_ahbl_slave #(
    parameter int MEM_AWIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    localparam int IW    = MEM_AWIDTH - 2;
    localparam int WORDS = 2 ** IW;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic          dp_valid;
    logic          dp_write;
    logic [IW-1:0] dp_idx;
    logic [3:0]    dp_be;
    logic [31:0]   mem [WORDS];

    logic          accept;
    logic          addr_err;
    logic [3:0]    be;
    logic          unused_htrans0;

    // Only HTRANS[1] distinguishes an active transfer from IDLE/BUSY.
    assign unused_htrans0 = HTRANS[0];

    // A slave holding HREADYOUT low never takes a new address phase.
    assign accept = HSEL && HREADY && HTRANS[1] && HREADYOUT;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        addr_err = 1'b0;
        be       = 4'b0000;
        case (HSIZE)
            3'd0: be = 4'b0001 << HADDR[1:0];
            3'd1: begin
                be       = HADDR[1] ? 4'b1100 : 4'b0011;
                addr_err = HADDR[0];
            end
            3'd2: begin
                be       = 4'b1111;
                addr_err = (HADDR[1:0] != 2'b00);
            end
            default: addr_err = 1'b1;
        endcase
        if (HADDR[31:MEM_AWIDTH] != '0) addr_err = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_idx    <= '0;
            dp_be     <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        state     <= ST_IDLE;
                        wait_cnt  <= '0;
                        HREADYOUT <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    // IDLE and ERR2 both end a data phase, so a new address phase may start here.
                    state     <= ST_IDLE;
                    dp_valid  <= 1'b0;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    if (accept) begin
                        dp_idx   <= HADDR[MEM_AWIDTH-1:2];
                        dp_be    <= be;
                        dp_write <= HWRITE;
                        if (addr_err) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else begin
                            dp_valid <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                state     <= ST_WAIT;
                                wait_cnt  <= 4'(WAIT_STATES);
                                HREADYOUT <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: the memory array has no reset; its contents are undefined at power-up and survive HRESET.
    always_ff @(posedge HCLK) begin
        if (!HRESET && dp_valid && dp_write && HREADYOUT) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_be[i]) mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    // Read data is taken from the array after any write committed at the previous edge.
    assign HRDATA = (dp_valid && !dp_write && HREADYOUT && !HRESP) ? mem[dp_idx] : 32'h0;

endmodule

// File: tb/tb_bfm_ahbl_slave.sv
// Bench for bfm_ahbl_slave: two instances (0 and 3 wait states) checked every
// cycle against a transaction-level model with a byte-addressed memory.
module tb_bfm_ahbl_slave;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic [1:0]       hreset = 2'b11;
    logic [1:0]       hsel   = 2'b00;
    logic [1:0]       hwrite = 2'b00;
    logic [1:0][1:0]  htrans = '0;
    logic [1:0][2:0]  hsize  = '0;
    logic [1:0][31:0] haddr  = '0;
    logic [1:0][31:0] hwdata = '0;

    logic        out_rdy0, out_rdy1, out_resp0, out_resp1;
    logic [31:0] out_rdata0, out_rdata1;
    logic [1:0]       rdy_v, resp_v;
    logic [1:0][31:0] rdata_v;
    assign rdy_v   = {out_rdy1, out_rdy0};
    assign resp_v  = {out_resp1, out_resp0};
    assign rdata_v = {out_rdata1, out_rdata0};

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  chk_en = 2'b00;
    exp_t        exp_q [2][$];
    exp_t        cur;
    logic [7:0]  mdl_mem [2][4096];
    bit          pend_wr [2];
    logic [31:0] pend_addr [2];
    logic [31:0] pend_wdata [2];
    logic [2:0]  pend_size [2];
    int          cur_len [2];

    bfm_ahbl_slave #(.MEM_AWIDTH(12), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]),
        .HREADY(out_rdy0), .HREADYOUT(out_rdy0), .HRESP(out_resp0), .HRDATA(out_rdata0)
    );

    bfm_ahbl_slave #(.MEM_AWIDTH(12), .WAIT_STATES(3)) dut1 (
        .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]),
        .HREADY(out_rdy1), .HREADYOUT(out_rdy1), .HRESP(out_resp1), .HRDATA(out_rdata1)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int ws(int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_word(int d, logic [31:0] a);
        int b;
        b = int'(a & 32'hFFC);
        return {mdl_mem[d][b+3], mdl_mem[d][b+2], mdl_mem[d][b+1], mdl_mem[d][b]};
    endfunction

    task automatic mdl_write(int d, logic [31:0] a, logic [2:0] sz, logic [31:0] w);
        for (int k = 0; k < (1 << sz); k++) begin
            int b;
            b = int'(a) + k;
            mdl_mem[d][b] = w[8*(b%4) +: 8];
        end
    endtask

    task automatic push(int d, logic r, logic s, logic [31:0] v);
        exp_t e;
        e.rdy   = r;
        e.resp  = s;
        e.rdata = v;
        exp_q[d].push_back(e);
    endtask

    task automatic drive(int d, logic sel, logic [1:0] tr, logic wr, logic [2:0] sz, logic [31:0] a);
        hsel[d]   = sel;
        htrans[d] = tr;
        hwrite[d] = wr;
        hsize[d]  = sz;
        haddr[d]  = a;
        hwdata[d] = pend_wdata[d];
    endtask

    // Drives one address phase, holds it for the length of the current data
    // phase, then predicts the outputs of the data phase it opens.
    task automatic issue(int d, logic sel, logic [1:0] tr, logic wr, logic [2:0] sz,
                         logic [31:0] a, logic [31:0] w);
        bit act, err;
        drive(d, sel, tr, wr, sz, a);
        repeat (cur_len[d]) @(posedge clk);
        #1;
        if (pend_wr[d]) mdl_write(d, pend_addr[d], pend_size[d], pend_wdata[d]);
        pend_wr[d]    = 1'b0;
        pend_wdata[d] = w;
        act = sel && tr[1];
        err = act && (sz > 3'd2 || (a % (32'd1 << sz)) != 0 || a >= 32'h1000);
        if (!act) begin
            push(d, 1'b1, 1'b0, 32'h0);
            cur_len[d] = 1;
        end else if (err) begin
            push(d, 1'b0, 1'b1, 32'h0);
            push(d, 1'b1, 1'b1, 32'h0);
            cur_len[d] = 2;
        end else begin
            for (int i = 0; i < ws(d); i++) push(d, 1'b0, 1'b0, 32'h0);
            push(d, 1'b1, 1'b0, wr ? 32'h0 : mdl_word(d, a));
            cur_len[d] = ws(d) + 1;
            if (wr) begin
                pend_wr[d]   = 1'b1;
                pend_addr[d] = a;
                pend_size[d] = sz;
            end
        end
    endtask

    task automatic lit(int d, string name, logic r, logic s, logic [31:0] v);
        #2;
        check({name, "_rdy"},   32'(rdy_v[d]),  32'(r));
        check({name, "_resp"},  32'(resp_v[d]), 32'(s));
        check({name, "_rdata"}, rdata_v[d],     v);
    endtask

    task automatic do_reset(int d, int n);
        chk_en[d] = 1'b0;
        exp_q[d].delete();
        pend_wr[d] = 1'b0;
        hreset[d]  = 1'b1;
        drive(d, 1'b0, T_IDLE, 1'b0, 3'd0, 32'h0);
        repeat (n) @(posedge clk);
        #1;
        hreset[d] = 1'b0;
        check($sformatf("dut%0d_rst_rdy", d),   32'(rdy_v[d]),  32'd1);
        check($sformatf("dut%0d_rst_resp", d),  32'(resp_v[d]), 32'd0);
        check($sformatf("dut%0d_rst_rdata", d), rdata_v[d],     32'h0);
        push(d, 1'b1, 1'b0, 32'h0);
        cur_len[d] = 1;
        chk_en[d]  = 1'b1;
    endtask

    task automatic flush(int d);
        drive(d, 1'b0, T_IDLE, 1'b0, 3'd0, 32'h0);
        repeat (cur_len[d]) @(posedge clk);
        #1;
        chk_en[d] = 1'b0;
        check($sformatf("dut%0d_drain", d), 32'(exp_q[d].size()), 32'd0);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (chk_en[d]) begin
                if (exp_q[d].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dut%0d_queue: got empty expected one entry", d);
                end else begin
                    cur = exp_q[d].pop_front();
                    check($sformatf("dut%0d_hreadyout", d), 32'(rdy_v[d]),  32'(cur.rdy));
                    check($sformatf("dut%0d_hresp", d),     32'(resp_v[d]), 32'(cur.resp));
                    check($sformatf("dut%0d_hrdata", d),    rdata_v[d],     cur.rdata);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            pend_wr[d]    = 1'b0;
            pend_wdata[d] = 32'h0;
            pend_addr[d]  = 32'h0;
            pend_size[d]  = 3'd0;
            cur_len[d]    = 1;
        end

        // ---------------- zero wait states ----------------
        do_reset(0, 2);
        issue(0, 1, T_NSEQ, 1, 3'd2, 32'h010, 32'hDEADBEEF);
        issue(0, 1, T_NSEQ, 0, 3'd2, 32'h010, 32'h0);
        check("mdl031", mdl_word(0, 32'h010), 32'hDEADBEEF);
        lit(0, "r031", 1'b1, 1'b0, 32'hDEADBEEF);

        issue(0, 1, T_NSEQ, 1, 3'd2, 32'h010, 32'h11223344);
        issue(0, 1, T_NSEQ, 1, 3'd0, 32'h013, 32'hAA556677);
        issue(0, 1, T_NSEQ, 0, 3'd2, 32'h010, 32'h0);
        check("mdl032", mdl_word(0, 32'h010), 32'hAA223344);
        lit(0, "r032", 1'b1, 1'b0, 32'hAA223344);

        issue(0, 1, T_NSEQ, 1, 3'd2, 32'h014, 32'h00000000);
        issue(0, 1, T_SEQ,  1, 3'd1, 32'h016, 32'hBEEF1234);
        issue(0, 1, T_NSEQ, 1, 3'd0, 32'h014, 32'h5A5A5A5A);
        issue(0, 1, T_NSEQ, 0, 3'd2, 32'h014, 32'h0);
        check("mdl_half", mdl_word(0, 32'h014), 32'hBEEF005A);

        issue(0, 1, T_NSEQ, 1, 3'd2, 32'h000, 32'hCAFEF00D);
        issue(0, 1, T_NSEQ, 1, 3'd1, 32'h001, 32'h12345678);
        fork
            issue(0, 1, T_NSEQ, 0, 3'd2, 32'h1000, 32'h0);
            begin
                lit(0, "e034a", 1'b0, 1'b1, 32'h0);
                @(posedge clk); #1;
                lit(0, "e034b", 1'b1, 1'b1, 32'h0);
            end
        join
        issue(0, 1, T_IDLE, 0, 3'd2, 32'h000, 32'h0);
        issue(0, 1, T_NSEQ, 0, 3'd2, 32'h000, 32'h0);
        lit(0, "r034", 1'b1, 1'b0, 32'hCAFEF00D);
        issue(0, 1, T_NSEQ, 0, 3'd3, 32'h020, 32'h0);
        issue(0, 1, T_NSEQ, 0, 3'd2, 32'h010, 32'h0);

        issue(0, 1, T_NSEQ, 1, 3'd2, 32'h018, 32'h55AA55AA);
        issue(0, 1, T_BUSY, 1, 3'd2, 32'h010, 32'hFFFFFFFF);
        issue(0, 0, T_NSEQ, 1, 3'd2, 32'h010, 32'h00000000);
        issue(0, 1, T_NSEQ, 0, 3'd2, 32'h018, 32'h0);
        issue(0, 0, T_SEQ,  1, 3'd2, 32'h018, 32'h0);
        issue(0, 1, T_BUSY, 1, 3'd2, 32'h018, 32'h0);
        issue(0, 1, T_NSEQ, 0, 3'd2, 32'h010, 32'h0);
        lit(0, "r036", 1'b1, 1'b0, 32'hAA223344);
        flush(0);

        // ---------------- three wait states ----------------
        do_reset(1, 2);
        issue(1, 1, T_NSEQ, 1, 3'd2, 32'h040, 32'h0BADF00D);
        issue(1, 1, T_NSEQ, 0, 3'd2, 32'h040, 32'h0);
        fork
            issue(1, 0, T_IDLE, 0, 3'd0, 32'h0, 32'h0);
            for (int i = 0; i < 4; i++) begin
                lit(1, $sformatf("r033_c%0d", i), (i == 3), 1'b0, (i == 3) ? 32'h0BADF00D : 32'h0);
                if (i < 3) begin
                    @(posedge clk); #1;
                end
            end
        join

        issue(1, 1, T_NSEQ, 1, 3'd2, 32'h040, 32'h12345678);
        drive(1, 1'b0, T_IDLE, 1'b0, 3'd0, 32'h0);
        @(posedge clk); #1;
        do_reset(1, 1);
        issue(1, 1, T_NSEQ, 0, 3'd2, 32'h040, 32'h0);
        check("mdl035", mdl_word(1, 32'h040), 32'h0BADF00D);

        issue(1, 1, T_NSEQ, 1, 3'd1, 32'h043, 32'h0000FFFF);
        issue(1, 1, T_NSEQ, 1, 3'd0, 32'h043, 32'hFF000000);
        issue(1, 1, T_BUSY, 1, 3'd2, 32'h040, 32'h0);
        issue(1, 0, T_NSEQ, 1, 3'd2, 32'h040, 32'h0);
        issue(1, 1, T_SEQ,  0, 3'd2, 32'h040, 32'h0);
        check("mdl_byte1", mdl_word(1, 32'h040), 32'hFFADF00D);
        flush(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bfm_ahbl_slave.md
BFM_AHBL_SLAVE -- requirements
Module: bfm_ahbl_slave

Interface
REQ-001 SHALL provide parameter MEM_AWIDTH, default 12, giving the byte-address width of the internal memory (2^MEM_AWIDTH bytes, 32-bit words).
REQ-002 SHALL provide parameter WAIT_STATES, default 0, range 0..15, giving the wait cycles inserted per OKAY transfer.
REQ-003 SHALL provide port HCLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL provide port HRESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL provide port HSEL, input, 1 bit: slave select.
REQ-006 SHALL provide port HADDR, input, 32 bits: byte address.
REQ-007 SHALL provide port HTRANS, input, 2 bits: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 SHALL provide port HWRITE, input, 1 bit: 1 = write.
REQ-009 SHALL provide port HSIZE, input, 3 bits: transfer size (0 = byte, 1 = half, 2 = word).
REQ-010 SHALL provide port HWDATA, input, 32 bits: write data, valid in the data phase.
REQ-011 SHALL provide port HREADY, input, 1 bit: bus-level ready; the previous transfer is complete.
REQ-012 SHALL provide port HREADYOUT, output, 1 bit: this slave's ready.
REQ-013 SHALL provide port HRESP, output, 1 bit: 0 = OKAY, 1 = ERROR.
REQ-014 SHALL provide port HRDATA, output, 32 bits: read data.

Function
REQ-015 Address phase SHALL be accepted only when HSEL=1, HREADY=1 and HTRANS[1]=1; HADDR, HWRITE and HSIZE are registered at that edge.
REQ-016 HTRANS IDLE/BUSY, or HSEL=0 with HREADY=1, SHALL produce a zero-wait OKAY data phase with no memory access.
REQ-017 The accepted transfer SHALL be flagged ERROR if any of these holds: HSIZE>2; HADDR not aligned to the size; HADDR[31:MEM_AWIDTH] != 0.
REQ-018 The FSM SHALL have four states: IDLE, WAIT, ERR1, ERR2.
REQ-019 FSM transitions: IDLE->WAIT on a valid accept when WAIT_STATES>0; IDLE->ERR1 on an error accept; IDLE stays IDLE on a valid accept when WAIT_STATES=0 (data phase completes the next cycle).
REQ-020 In WAIT, HREADYOUT SHALL be 0 and HRESP 0; a counter loaded with WAIT_STATES decrements each cycle; at 1 the FSM returns to IDLE, giving HREADYOUT=1 the following cycle.
REQ-021 OKAY latency SHALL be exactly WAIT_STATES+1 cycles from the address-phase edge to the HREADYOUT=1 data-phase cycle.
REQ-022 Error response SHALL be two cycles: ERR1 drives HREADYOUT=0, HRESP=1; ERR2 drives HREADYOUT=1, HRESP=1; then IDLE; no memory access occurs.
REQ-023 Writes SHALL commit on the data-phase edge where HREADYOUT=1, updating only the addressed byte lanes (byte: lane HADDR[1:0]; half: lanes 1:0 or 3:2 by HADDR[1]; word: all four).
REQ-024 HRDATA SHALL present the full addressed word, all lanes, in the read data phase whenever HREADYOUT=1 and HRESP=0; otherwise it SHALL be 0.
REQ-025 A read immediately following a write to the same word (back-to-back pipelined) SHALL return the newly written data.
REQ-026 A new address phase SHALL be accepted in the same cycle as a completing data phase (HREADYOUT=1, including ERR2); none is accepted while HREADYOUT=0.
REQ-027 When an ERROR response is in progress and the master drives IDLE during ERR2, that IDLE SHALL be accepted normally.
REQ-028 Memory contents SHALL be undefined at power-up and are not cleared by reset.

Reset
REQ-029 While HRESET=1 at a clock edge: FSM -> IDLE, wait counter 0, registered address-phase flags cleared, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-030 Reset asserted mid-transfer (WAIT/ERR1/ERR2) SHALL abandon the transfer without a memory write; the first accept is possible on the first edge after HRESET falls.

Verification
REQ-031 WAIT_STATES=0: word write 0xDEADBEEF to 0x010, then read 0x010 back-to-back -> HREADYOUT stays 1 and HRDATA=0xDEADBEEF in the read data phase.
REQ-032 Byte write 0xAA to 0x013 over word 0x11223344 -> word read of 0x010 returns 0xAA223344.
REQ-033 WAIT_STATES=3: NONSEQ read -> HREADYOUT=0 for exactly 3 cycles, then 1 with HRESP=0.
REQ-034 Half write to 0x001 (unaligned), then word read to 0x1000 with MEM_AWIDTH=12 -> each gives HRESP=1 for two cycles, HREADYOUT 0 then 1; memory unchanged.
REQ-035 HRESET=1 during the second wait cycle of a write -> next cycle HREADYOUT=1, HRESP=0; a later read of that address shows the old value.
REQ-036 HTRANS=BUSY and HSEL=0 cycles interleaved with NONSEQ transfers -> zero-wait OKAY and no memory change.
